// File: rtl/keypad_scan_pkg.sv
// Shared keypad-matrix constants used by the keypad reader and the display scan.
package keypad_scan_pkg;
    localparam int KEY_ROWS         = 4;
    localparam int KEY_COLS         = 4;
    localparam int KEY_NUM          = KEY_ROWS * KEY_COLS;
    localparam int KEY_CODE_W       = $clog2(KEY_NUM);
    localparam int SCAN_DIV_DEFAULT = 100_000;

    // Classification of one complete scan of the matrix.
    typedef enum logic [1:0] {
        CAND_NONE,
        CAND_SINGLE,
        CAND_MULTI
    } cand_kind_e;
endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix lines plus the debounced key event bus towards the data path.
interface keypad_scan_if;
    import keypad_scan_pkg::*;

    logic [KEY_COLS-1:0]   col;
    logic [KEY_ROWS-1:0]   row;
    logic [KEY_CODE_W-1:0] key_code;
    logic                  key_valid;
    logic                  key_held;

    modport master (
        input  col,
        output row, key_code, key_valid, key_held
    );

    modport slave (
        output col,
        input  row, key_code, key_valid, key_held
    );
endinterface

// File: rtl/keypad_scan_tick.sv
// Row-period prescaler: counts 0..DIV-1 and pulses tick for one clk at DIV-1.
module keypad_scan_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);
endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad reader: one-cold row scan, 2-flop column sync, whole-scan debounce,
// one-clk key_valid per accepted press and key_held until debounced release.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV       = SCAN_DIV_DEFAULT,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master bus
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } state_e;

    logic                  tick;
    logic                  eos;
    logic                  accept;
    logic [KEY_COLS-1:0]   col_meta_q, col_sync_q;
    logic [1:0]            row_idx_q;
    logic [KEY_ROWS-1:0]   row_q;
    logic [KEY_NUM-1:0]    scan_vec_q, scan_vec_d;
    cand_kind_e            kind;
    logic [KEY_CODE_W-1:0] cand;
    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [KEY_CODE_W-1:0] cand_q, key_code_q;
    logic                  key_valid_q, key_held_q;

    keypad_scan_tick #(.DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        col_meta_q <= bus.col;
        col_sync_q <= col_meta_q;
    end

    // The FSM must see the row sampled on this very tick, so it works on the merged vector.
    always_comb begin
        scan_vec_d = scan_vec_q;
        if (tick) begin
            scan_vec_d[row_idx_q*KEY_COLS +: KEY_COLS] = ~col_sync_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_idx_q  <= 2'd0;
            row_q      <= 4'b1110;
            scan_vec_q <= '0;
        end else if (tick) begin
            row_idx_q  <= row_idx_q + 2'd1;
            row_q      <= ~(4'b0001 << (row_idx_q + 2'd1));
            scan_vec_q <= scan_vec_d;
        end
    end

    assign eos = tick && (row_idx_q == 2'd3);

    always_comb begin
        kind = CAND_NONE;
        cand = '0;
        case ($countones(scan_vec_d))
            0:       kind = CAND_NONE;
            1:       kind = CAND_SINGLE;
            default: kind = CAND_MULTI;
        endcase
        for (int i = 0; i < KEY_NUM; i++) begin
            if (scan_vec_d[i]) cand = KEY_CODE_W'(i);
        end
    end

    always_comb begin
        accept = 1'b0;
        if (eos && kind == CAND_SINGLE) begin
            if (state_q == S_IDLE) begin
                accept = (DEBOUNCE_SCANS == 1);
            end else if (state_q == S_DEBOUNCE) begin
                accept = (cand == cand_q) && (cnt_q + CNT_ONE == CNT_DONE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (accept) begin
                key_code_q  <= cand;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
            end
            if (eos) begin
                unique case (state_q)
                    S_IDLE: begin
                        if (kind == CAND_SINGLE) begin
                            cand_q  <= cand;
                            cnt_q   <= CNT_ONE;
                            state_q <= accept ? S_PRESSED : S_DEBOUNCE;
                        end
                    end
                    S_DEBOUNCE: begin
                        if (kind != CAND_SINGLE) begin
                            state_q <= S_IDLE;
                        end else if (cand == cand_q) begin
                            cnt_q <= cnt_q + CNT_ONE;
                            if (accept) state_q <= S_PRESSED;
                        end else begin
                            cand_q <= cand;
                            cnt_q  <= CNT_ONE;
                        end
                    end
                    S_PRESSED: begin
                        if (kind == CAND_NONE) begin
                            if (CNT_ONE == CNT_DONE) begin
                                key_held_q <= 1'b0;
                                state_q    <= S_IDLE;
                            end else begin
                                cnt_q   <= CNT_ONE;
                                state_q <= S_RELEASE;
                            end
                        end
                    end
                    S_RELEASE: begin
                        if (kind != CAND_NONE) begin
                            state_q <= S_PRESSED;
                        end else if (cnt_q + CNT_ONE == CNT_DONE) begin
                            key_held_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.row       = row_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_held  = key_held_q;
endmodule
